// File: rtl/key_event.sv
// key_event: turns a debounced, clock-synchronous key level into single-cycle
// event strobes (press, release, short-press, long-press, auto-repeat) plus a
// registered "held" level. One instance per key.
module key_event #(
   parameter logic        PRESSED_LVL = 1'b0,
   parameter int unsigned LONG_CYC    = 25_000_000,
   parameter int unsigned REPEAT_CYC  = 5_000_000,
   parameter int unsigned CNT_W       = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic held,
   output logic press_p,
   output logic release_p,
   output logic short_p,
   output logic long_p,
   output logic repeat_p
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 32'd1);
   // With repeat disabled the compare value is never used; keep it at zero
   // so the subtraction cannot underflow.
   localparam logic [CNT_W-1:0] REPEAT_LAST = (REPEAT_CYC == 32'd0) ? CNT_ZERO
                                              : CNT_W'(REPEAT_CYC - 32'd1);
   localparam logic             REPEAT_EN   = (REPEAT_CYC != 32'd0);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             pressed_s;

   logic             held_r;
   logic             press_r;
   logic             release_r;
   logic             short_r;
   logic             long_r;
   logic             repeat_r;

   logic             held_nxt_s;
   logic             press_nxt_s;
   logic             release_nxt_s;
   logic             short_nxt_s;
   logic             long_nxt_s;
   logic             repeat_nxt_s;

   assign pressed_s = (key == PRESSED_LVL);

   // State and hold-counter register; reset drops any hold in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state and counter logic; the counter restarts at every threshold so it never wraps.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (pressed_s) begin
               state_nxt_s = ST_PRESSED;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         ST_PRESSED: begin
            if (!pressed_s) begin
               // A release on the threshold sample wins: it is a short press.
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == LONG_LAST) begin
               state_nxt_s = ST_LONG;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_PRESSED;
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_LONG: begin
            if (!pressed_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (!REPEAT_EN) begin
               state_nxt_s = ST_LONG;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == REPEAT_LAST) begin
               state_nxt_s = ST_LONG;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = ST_LONG;
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Next values of the registered outputs; strobes default low every cycle.
   always_comb begin
      held_nxt_s    = 1'b0;
      press_nxt_s   = 1'b0;
      release_nxt_s = 1'b0;
      short_nxt_s   = 1'b0;
      long_nxt_s    = 1'b0;
      repeat_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pressed_s) begin
               held_nxt_s  = 1'b1;
               press_nxt_s = 1'b1;
            end else begin
               held_nxt_s  = 1'b0;
            end
         end
         ST_PRESSED: begin
            if (!pressed_s) begin
               release_nxt_s = 1'b1;
               short_nxt_s   = 1'b1;
            end else if (cnt_r == LONG_LAST) begin
               held_nxt_s    = 1'b1;
               long_nxt_s    = 1'b1;
            end else begin
               held_nxt_s    = 1'b1;
            end
         end
         ST_LONG: begin
            if (!pressed_s) begin
               release_nxt_s = 1'b1;
            end else if (REPEAT_EN && (cnt_r == REPEAT_LAST)) begin
               held_nxt_s    = 1'b1;
               repeat_nxt_s  = 1'b1;
            end else begin
               held_nxt_s    = 1'b1;
            end
         end
         default: begin
            held_nxt_s = 1'b0;
         end
      endcase
   end

   // Output registers; reset clears the level and drops any strobe in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         held_r    <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         short_r   <= 1'b0;
         long_r    <= 1'b0;
         repeat_r  <= 1'b0;
      end else begin
         held_r    <= held_nxt_s;
         press_r   <= press_nxt_s;
         release_r <= release_nxt_s;
         short_r   <= short_nxt_s;
         long_r    <= long_nxt_s;
         repeat_r  <= repeat_nxt_s;
      end
   end

   assign held      = held_r;
   assign press_p   = press_r;
   assign release_p = release_r;
   assign short_p   = short_r;
   assign long_p    = long_r;
   assign repeat_p  = repeat_r;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed scenarios for key_event. Expected output events
// (strobes and changes of held) are pushed with their cycle stamp; a monitor
// process pops and compares whenever a DUT presents an event.
module tb_key_event;

   localparam int unsigned LONG_T = 10;
   localparam int unsigned REP_T  = 4;
   localparam int unsigned W      = 8;

   // Event vector layout: {held, press, release, short, long, repeat}
   localparam logic [5:0] E_PRESS     = 6'b110000;
   localparam logic [5:0] E_REL_SHORT = 6'b001100;
   localparam logic [5:0] E_REL       = 6'b001000;
   localparam logic [5:0] E_LONG      = 6'b100010;
   localparam logic [5:0] E_REP       = 6'b100001;
   localparam logic [5:0] E_DROP      = 6'b000000;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic key0 = 1'b1;
   logic key1 = 1'b1;

   logic held0, press0, rel0, short0, long0, rep0;
   logic held1, press1, rel1, short1, long1, rep1;

   typedef struct {
      int         inst;
      int         cyc;
      logic [5:0] ev;
   } exp_t;

   exp_t       sb[$];
   int         cyc       = 0;
   int         checks    = 0;
   int         errors    = 0;
   bit         mon_en    = 1'b0;
   bit         fin_req   = 1'b0;
   bit         fin_done  = 1'b0;
   logic [1:0] prev_held = 2'b00;
   int         base;

   key_event #(
      .PRESSED_LVL(1'b0), .LONG_CYC(LONG_T), .REPEAT_CYC(REP_T), .CNT_W(W)
   ) u_dut0 (
      .clk(clk), .rst(rst), .key(key0), .held(held0), .press_p(press0),
      .release_p(rel0), .short_p(short0), .long_p(long0), .repeat_p(rep0)
   );

   key_event #(
      .PRESSED_LVL(1'b0), .LONG_CYC(LONG_T), .REPEAT_CYC(0), .CNT_W(W)
   ) u_dut1 (
      .clk(clk), .rst(rst), .key(key1), .held(held1), .press_p(press1),
      .release_p(rel1), .short_p(short1), .long_p(long1), .repeat_p(rep1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int inst, input int c, input logic [5:0] ev);
      exp_t e;
      e.inst = inst;
      e.cyc  = c;
      e.ev   = ev;
      sb.push_back(e);
   endtask

   function automatic int first_of(input int inst);
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].inst == inst) return i;
      end
      return -1;
   endfunction

   task automatic press_hold(input int inst, input int n);
      if (inst == 0) key0 = 1'b0; else key1 = 1'b0;
      repeat (n) @(negedge clk);
      if (inst == 0) key0 = 1'b1; else key1 = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Monitor: compares every observed event against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            logic [5:0] o;
            logic       seen;
            int         idx;
            o    = (k == 0) ? {held0, press0, rel0, short0, long0, rep0}
                            : {held1, press1, rel1, short1, long1, rep1};
            seen = (o[4:0] != 5'd0) || (o[5] != prev_held[k]);
            prev_held[k] = o[5];
            idx = first_of(k);
            while (idx >= 0 && sb[idx].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL missing_event inst=%0d: nothing at cycle %0d, required %b",
                        k, sb[idx].cyc, sb[idx].ev);
               sb.delete(idx);
               idx = first_of(k);
            end
            if (idx >= 0 && sb[idx].cyc == cyc) begin
               checks++;
               if (o !== sb[idx].ev) begin
                  errors++;
                  $display("FAIL event inst=%0d cycle=%0d: got %b, required %b",
                           k, cyc, o, sb[idx].ev);
               end
               sb.delete(idx);
            end else if (seen) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event inst=%0d cycle=%0d: got %b, required none",
                        k, cyc, o);
            end
         end
         if (fin_req && !fin_done) begin
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
            end
            fin_done = 1'b1;
         end
      end
   end

   initial begin
      // 1. Reset held for 3 edges with key toggling, then released with key up.
      rst  = 1'b0;
      key0 = 1'b0;
      key1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      key0   = 1'b1;
      key1   = 1'b1;
      @(negedge clk);
      key0 = 1'b0;
      key1 = 1'b0;
      @(negedge clk);
      rst  = 1'b1;
      key0 = 1'b1;
      key1 = 1'b1;
      repeat (5) @(negedge clk);

      // 2. Short press of 5 samples.
      base = cyc;
      expect_ev(0, base + 1, E_PRESS);
      expect_ev(0, base + 6, E_REL_SHORT);
      press_hold(0, 5);

      // 3. Long hold of 20 samples: long after 10, repeats after 14 and 18.
      base = cyc;
      expect_ev(0, base + 1,  E_PRESS);
      expect_ev(0, base + 10, E_LONG);
      expect_ev(0, base + 14, E_REP);
      expect_ev(0, base + 18, E_REP);
      expect_ev(0, base + 21, E_REL);
      press_hold(0, 20);

      // 4a. 9 samples: release lands on the threshold sample, so it is short.
      base = cyc;
      expect_ev(0, base + 1,  E_PRESS);
      expect_ev(0, base + 10, E_REL_SHORT);
      press_hold(0, 9);

      // 4b. Exactly 10 samples: long, then a plain release.
      base = cyc;
      expect_ev(0, base + 1,  E_PRESS);
      expect_ev(0, base + 10, E_LONG);
      expect_ev(0, base + 11, E_REL);
      press_hold(0, 10);

      // 4c. Minimum press: one pressed sample.
      base = cyc;
      expect_ev(0, base + 1, E_PRESS);
      expect_ev(0, base + 2, E_REL_SHORT);
      press_hold(0, 1);

      // 5. Repeat disabled instance: 30 samples, one long, no repeats.
      base = cyc;
      expect_ev(1, base + 1,  E_PRESS);
      expect_ev(1, base + 10, E_LONG);
      expect_ev(1, base + 31, E_REL);
      press_hold(1, 30);

      // 6. Reset at sample 12 for 2 edges while the key stays down.
      base = cyc;
      expect_ev(0, base + 1,  E_PRESS);
      expect_ev(0, base + 10, E_LONG);
      expect_ev(0, base + 12, E_DROP);
      expect_ev(0, base + 14, E_PRESS);
      expect_ev(0, base + 23, E_LONG);
      expect_ev(0, base + 24, E_REL);
      key0 = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      key0 = 1'b1;
      repeat (4) @(negedge clk);

      fin_req = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
